main_behavioral: RTL and testbench

- Disaster-relief request scheduler with three request queues: Shelter (priority queue), Food (priority queue) and Evacuation (FIFO).
- Requests are inserted by resource type.
- An Evacuation insert cancels pending Shelter/Food requests from the same zone.
- A single output port presents the next request to serve; Evacuation always has precedence over Shelter and Food.

---
 rtl/main_behavioral.sv | 217 +++++++++++++++++++++
 tb/tb_main_behavioral.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/main_behavioral.sv
//------------------------------------------------------------------------------
// main_behavioral : disaster-relief request scheduler (Shelter/Food PQs + Evac FIFO)
// Optional feature macro: PRIORITY_AGING_EN (age-based priority boost)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module main_behavioral #(
  parameter int PQ_DEPTH   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int AGE_LIMIT  = 8
) (
  input  logic       Clock,
  input  logic       Reset_Queue,
  input  logic       Insert,
  input  logic       Serve,
  input  logic [7:0] Zone,
  input  logic [1:0] Priority,
  input  logic [1:0] Resource_line,
  output logic       Food_00,
  output logic       Shelter_01,
  output logic       Evacuation_10,
  output logic       Shelter_Full,
  output logic       Food_Full,
  output logic       Evac_Empty,
  output logic       Shelter_Valid,
  output logic       Shelter_Boost,
  output logic       Food_Valid,
  output logic       Food_Boost,
  output logic [7:0] Output_Zone,
  output logic [1:0] Output_Priority
);

  localparam int IW = (PQ_DEPTH > 1) ? $clog2(PQ_DEPTH) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Queue index 0 is Food and 1 is Shelter, matching their Resource_line codes.
  logic [PQ_DEPTH-1:0] pq_valid [2];
  logic [7:0]          pq_zone  [2][PQ_DEPTH];
  logic [1:0]          pq_prio  [2][PQ_DEPTH];
  logic [1:0]          eff_prio [2][PQ_DEPTH];
  logic [PQ_DEPTH-1:0] boosted  [2];

`ifdef PRIORITY_AGING_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);
  logic [AW-1:0] pq_age   [2][PQ_DEPTH];
  logic [AW-1:0] best_age [2];
`else
  logic unused_cfg;
  assign unused_cfg = (AGE_LIMIT != 0);
`endif

  logic [7:0]    fifo_zone [FIFO_DEPTH];
  logic [1:0]    fifo_prio [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] fifo_count;

  logic [IW-1:0]       win_idx  [2];
  logic [1:0]          win_prio [2];
  logic [1:0]          win_valid;
  logic [1:0]          win_boost;
  logic                evac_sel;
  logic                shel_sel;
  logic                food_sel;
  logic [PQ_DEPTH-1:0] serve_mask  [2];
  logic [PQ_DEPTH-1:0] ins_mask    [2];
  logic [PQ_DEPTH-1:0] cancel_mask [2];
  logic                evac_ins;
  logic                fifo_pop;
  logic                fifo_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int q = 0; q < 2; q++) begin
      boosted[q] = '0;
      for (int i = 0; i < PQ_DEPTH; i++) begin
`ifdef PRIORITY_AGING_EN
        boosted[q][i] = (pq_age[q][i] == AW'(AGE_LIMIT));
`endif
        eff_prio[q][i] = boosted[q][i] ? ((pq_prio[q][i] == 2'd3) ? 2'd3 : pq_prio[q][i] + 2'd1)
                                       : pq_prio[q][i];
      end
    end
  end

  // Winner: highest effective priority, then oldest, then lowest slot.
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      logic better;
      win_idx[q]   = '0;
      win_prio[q]  = '0;
      win_valid[q] = 1'b0;
      win_boost[q] = 1'b0;
`ifdef PRIORITY_AGING_EN
      best_age[q]  = '0;
`endif
      for (int i = 0; i < PQ_DEPTH; i++) begin
        better = !win_valid[q] || (eff_prio[q][i] > win_prio[q]);
`ifdef PRIORITY_AGING_EN
        better = better || ((eff_prio[q][i] == win_prio[q]) && (pq_age[q][i] > best_age[q]));
`endif
        if (pq_valid[q][i] && better) begin
          win_idx[q]   = IW'(i);
          win_prio[q]  = eff_prio[q][i];
          win_valid[q] = 1'b1;
          win_boost[q] = boosted[q][i];
`ifdef PRIORITY_AGING_EN
          best_age[q]  = pq_age[q][i];
`endif
        end
      end
    end
  end

  assign evac_sel = (fifo_count != '0);
  assign shel_sel = !evac_sel && win_valid[1] && (!win_valid[0] || (win_prio[1] >= win_prio[0]));
  assign food_sel = !evac_sel && !shel_sel && win_valid[0];

  assign Evacuation_10   = evac_sel;
  assign Shelter_01      = shel_sel;
  assign Food_00         = food_sel;
  assign Shelter_Full    = &pq_valid[1];
  assign Food_Full       = &pq_valid[0];
  assign Evac_Empty      = !evac_sel;
  assign Shelter_Valid   = win_valid[1];
  assign Food_Valid      = win_valid[0];
  assign Shelter_Boost   = win_valid[1] && win_boost[1];
  assign Food_Boost      = win_valid[0] && win_boost[0];
  assign Output_Zone     = evac_sel ? fifo_zone[rd_ptr] :
                           shel_sel ? pq_zone[1][win_idx[1]] :
                           food_sel ? pq_zone[0][win_idx[0]] : 8'd0;
  assign Output_Priority = evac_sel ? fifo_prio[rd_ptr] :
                           shel_sel ? win_prio[1] :
                           food_sel ? win_prio[0] : 2'd0;

  assign evac_ins  = Insert && (Resource_line == 2'b10);
  assign fifo_pop  = Serve && evac_sel;
  assign fifo_push = evac_ins && ((fifo_count != CW'(FIFO_DEPTH)) || fifo_pop);

  // Insert slot is picked after the served slot is released, so full+serve accepts.
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < PQ_DEPTH; i++) begin
        serve_mask[q][i]  = Serve && ((q == 0) ? food_sel : shel_sel) && (win_idx[q] == IW'(i));
        cancel_mask[q][i] = evac_ins && (pq_zone[q][i] == Zone);
        ins_mask[q][i]    = 1'b0;
        if (!found && !(pq_valid[q][i] && !serve_mask[q][i])) begin
          found          = 1'b1;
          ins_mask[q][i] = Insert && (Resource_line == 2'(q));
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_Queue) begin
      for (int q = 0; q < 2; q++) begin
        pq_valid[q] <= '0;
`ifdef PRIORITY_AGING_EN
        for (int i = 0; i < PQ_DEPTH; i++) pq_age[q][i] <= '0;
`endif
      end
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      for (int q = 0; q < 2; q++) begin
        for (int i = 0; i < PQ_DEPTH; i++) begin
          if (ins_mask[q][i]) begin
            pq_valid[q][i] <= 1'b1;
`ifdef PRIORITY_AGING_EN
            pq_age[q][i]   <= '0;
`endif
          end else if (serve_mask[q][i] || cancel_mask[q][i]) begin
            pq_valid[q][i] <= 1'b0;
`ifdef PRIORITY_AGING_EN
            pq_age[q][i]   <= '0;
          end else if (pq_valid[q][i] && (pq_age[q][i] != AW'(AGE_LIMIT))) begin
            pq_age[q][i]   <= pq_age[q][i] + 1'b1;
`endif
          end
        end
      end
      if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
      fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  // Payload storage needs no reset; validity is tracked separately.
  always_ff @(posedge Clock) begin
    if (Reset_Queue) begin
      for (int q = 0; q < 2; q++) begin
        for (int i = 0; i < PQ_DEPTH; i++) begin
          if (ins_mask[q][i]) begin
            pq_zone[q][i] <= Zone;
            pq_prio[q][i] <= Priority;
          end
        end
      end
      if (fifo_push) begin
        fifo_zone[wr_ptr] <= Zone;
        fifo_prio[wr_ptr] <= Priority;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_main_behavioral.sv
//------------------------------------------------------------------------------
// tb_main_behavioral : directed self-checking bench for main_behavioral
//------------------------------------------------------------------------------
`default_nettype none

module tb_main_behavioral;

  logic       clk = 1'b0;
  logic       rstn;
  logic       ins;
  logic       srv;
  logic [7:0] zone;
  logic [1:0] prio;
  logic [1:0] rl;
  logic       food_00, shelter_01, evac_10, s_full, f_full, e_empty;
  logic       s_valid, s_boost, f_valid, f_boost;
  logic [7:0] out_zone;
  logic [1:0] out_prio;
  logic [19:0] status;
  logic [19:0] e;
  int vectors = 0;
  int miscompares = 0;

  main_behavioral dut (
    .Clock(clk), .Reset_Queue(rstn), .Insert(ins), .Serve(srv), .Zone(zone),
    .Priority(prio), .Resource_line(rl), .Food_00(food_00), .Shelter_01(shelter_01),
    .Evacuation_10(evac_10), .Shelter_Full(s_full), .Food_Full(f_full),
    .Evac_Empty(e_empty), .Shelter_Valid(s_valid), .Shelter_Boost(s_boost),
    .Food_Valid(f_valid), .Food_Boost(f_boost), .Output_Zone(out_zone),
    .Output_Priority(out_prio)
  );

  always #5 clk = ~clk;

  assign status = {food_00, shelter_01, evac_10, s_full, f_full, e_empty,
                   s_valid, s_boost, f_valid, f_boost, out_zone, out_prio};

  // f = {food, shelter, evac, s_full, f_full, e_empty, s_valid, f_valid}; boosts are 0.
  function automatic logic [19:0] exp_st(input logic [7:0] f, input logic [7:0] z, input logic [1:0] p);
    return {f[7:1], 1'b0, f[0], 1'b0, z, p};
  endfunction

  task automatic cyc(input logic i, input logic s, input logic [1:0] r,
                     input logic [7:0] z, input logic [1:0] p);
    ins = i; srv = s; rl = r; zone = z; prio = p;
    @(posedge clk); #1;
    ins = 1'b0; srv = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    cyc(1'b1, 1'b0, 2'b01, 8'd99, 2'd3);
    rstn = 1'b1;
    e = exp_st(8'b000_00100, 8'd0, 2'd0); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL reset_state: got %h want %h", status, e); end
  endtask

  task automatic test_shelter_food;
    cyc(1'b1, 1'b0, 2'b01, 8'd12, 2'd1);
    e = exp_st(8'b010_00110, 8'd12, 2'd1); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL shelter_insert: got %h want %h", status, e); end
    cyc(1'b1, 1'b0, 2'b00, 8'd12, 2'd2);
    e = exp_st(8'b100_00111, 8'd12, 2'd2); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL food_higher_prio: got %h want %h", status, e); end
  endtask

  task automatic test_evac_cancel;
    cyc(1'b1, 1'b0, 2'b10, 8'd12, 2'd1);
    e = exp_st(8'b001_00000, 8'd12, 2'd1); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL evac_cancel: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b000_00100, 8'd0, 2'd0); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL evac_serve: got %h want %h", status, e); end
  endtask

  task automatic test_serve_order;
    cyc(1'b1, 1'b0, 2'b01, 8'd240, 2'd1);
    cyc(1'b1, 1'b0, 2'b00, 8'd15, 2'd2);
    e = exp_st(8'b100_00111, 8'd15, 2'd2); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL order_food_first: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b010_00110, 8'd240, 2'd1); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL order_shelter_next: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b000_00100, 8'd0, 2'd0); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL order_drained: got %h want %h", status, e); end
    cyc(1'b1, 1'b0, 2'b01, 8'd5, 2'd2);
    cyc(1'b1, 1'b0, 2'b00, 8'd6, 2'd2);
    e = exp_st(8'b010_00111, 8'd5, 2'd2); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL tie_to_shelter: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b100_00101, 8'd6, 2'd2); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL tie_food_after: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b000_00100, 8'd0, 2'd0); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL idle_serve_noop: got %h want %h", status, e); end
  endtask

  task automatic test_full;
    cyc(1'b1, 1'b0, 2'b01, 8'd1, 2'd0);
    cyc(1'b1, 1'b0, 2'b01, 8'd2, 2'd2);
    cyc(1'b1, 1'b0, 2'b01, 8'd3, 2'd1);
    cyc(1'b1, 1'b0, 2'b01, 8'd4, 2'd2);
    e = exp_st(8'b010_10110, 8'd2, 2'd2); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL shelter_full: got %h want %h", status, e); end
    cyc(1'b1, 1'b0, 2'b01, 8'd9, 2'd3);
    e = exp_st(8'b010_10110, 8'd2, 2'd2); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL full_insert_dropped: got %h want %h", status, e); end
    cyc(1'b1, 1'b1, 2'b01, 8'd7, 2'd3);
    e = exp_st(8'b010_10110, 8'd7, 2'd3); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL full_serve_insert: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b010_00110, 8'd4, 2'd2); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL drain_z4: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b010_00110, 8'd3, 2'd1); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL drain_z3: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b010_00110, 8'd1, 2'd0); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL drain_z1: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 2'b00, 8'(70 + i), 2'd1);
    e = exp_st(8'b100_01101, 8'd70, 2'd1); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL food_full: got %h want %h", status, e); end
    cyc(1'b1, 1'b0, 2'b10, 8'd72, 2'd0);
    e = exp_st(8'b001_00001, 8'd72, 2'd0); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL food_cancel_one: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b100_00101, 8'd71, 2'd1); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL food_after_cancel: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b000_00100, 8'd0, 2'd0); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL food_drained: got %h want %h", status, e); end
  endtask

  task automatic test_fifo_wrap;
    cyc(1'b1, 1'b0, 2'b10, 8'd21, 2'd0);
    cyc(1'b1, 1'b0, 2'b10, 8'd22, 2'd1);
    cyc(1'b1, 1'b0, 2'b10, 8'd23, 2'd2);
    e = exp_st(8'b001_00000, 8'd21, 2'd0); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL fifo_head: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    cyc(1'b1, 1'b0, 2'b10, 8'd24, 2'd3);
    cyc(1'b1, 1'b0, 2'b10, 8'd25, 2'd0);
    cyc(1'b1, 1'b0, 2'b10, 8'd26, 2'd1);
    cyc(1'b1, 1'b0, 2'b10, 8'd27, 2'd3);
    e = exp_st(8'b001_00000, 8'd23, 2'd2); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL fifo_full_head: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b001_00000, 8'd24, 2'd3); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL fifo_wrap_24: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b001_00000, 8'd25, 2'd0); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL fifo_wrap_25: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b001_00000, 8'd26, 2'd1); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL fifo_wrap_26: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b000_00100, 8'd0, 2'd0); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL fifo_drop_empty: got %h want %h", status, e); end
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 2'b10, 8'(31 + i), 2'd0);
    cyc(1'b1, 1'b1, 2'b10, 8'd35, 2'd2);
    e = exp_st(8'b001_00000, 8'd32, 2'd0); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL fifo_full_serve_insert: got %h want %h", status, e); end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b001_00000, 8'd35, 2'd2); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL fifo_accepted_35: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b000_00100, 8'd0, 2'd0); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL fifo_drained: got %h want %h", status, e); end
  endtask

  task automatic test_precedence;
    cyc(1'b1, 1'b0, 2'b01, 8'd30, 2'd3);
    cyc(1'b1, 1'b0, 2'b00, 8'd31, 2'd1);
    cyc(1'b1, 1'b0, 2'b10, 8'd40, 2'd0);
    e = exp_st(8'b001_00011, 8'd40, 2'd0); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL evac_precedence: got %h want %h", status, e); end
    cyc(1'b1, 1'b0, 2'b10, 8'd30, 2'd2);
    e = exp_st(8'b001_00001, 8'd40, 2'd0); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL cancel_zone_only: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b001_00001, 8'd30, 2'd2); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL evac_second: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b100_00101, 8'd31, 2'd1); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL food_after_evac: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    cyc(1'b1, 1'b0, 2'b11, 8'd77, 2'd3);
    e = exp_st(8'b000_00100, 8'd0, 2'd0); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL ignored_line: got %h want %h", status, e); end
  endtask

  task automatic test_back_to_back;
    cyc(1'b1, 1'b0, 2'b01, 8'd60, 2'd2);
    cyc(1'b1, 1'b0, 2'b01, 8'd61, 2'd1);
    cyc(1'b1, 1'b1, 2'b10, 8'd61, 2'd0);
    e = exp_st(8'b001_00000, 8'd61, 2'd0); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL serve_plus_evac: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    cyc(1'b1, 1'b0, 2'b00, 8'd80, 2'd1);
    cyc(1'b1, 1'b1, 2'b00, 8'd81, 2'd3);
    e = exp_st(8'b100_00101, 8'd81, 2'd3); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL serve_plus_food: got %h want %h", status, e); end
    cyc(1'b0, 1'b1, 2'b00, 8'd0, 2'd0);
    e = exp_st(8'b000_00100, 8'd0, 2'd0); vectors++;
    if (status !== e) begin miscompares++; $display("FAIL final_empty: got %h want %h", status, e); end
  endtask

  initial begin
    rstn = 1'b0; ins = 1'b0; srv = 1'b0; zone = 8'd0; prio = 2'd0; rl = 2'b00;
    test_reset();
    test_shelter_food();
    test_evac_cancel();
    test_serve_order();
    test_full();
    test_fifo_wrap();
    test_precedence();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
